banked_pair_regfile: RTL and testbench

//  Parametrised successor to the CPU register file: NREGS x DATA_W registers per bank, NBANKS banks.

---
 rtl/banked_pair_regfile.sv | 111 +++++++++++
 tb/tb_banked_pair_regfile.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_pair_regfile.sv
// Banked CPU register file with a 2*DATA_W pair update (inc/dec/add immediate)
// and a small bank stack for fast interrupt context switching.
module banked_pair_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int NBANKS = 2,
    parameter int IMM_W  = 8,
    localparam int AW    = $clog2(NREGS),
    localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_sel,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_b_sel,
    input  logic [1:0]        i_pair_op,
    input  logic [IMM_W-1:0]  i_pair_imm,
    input  logic              i_bank_push,
    input  logic              i_bank_pop,
    output logic [DATA_W-1:0] o_out_a,
    output logic [DATA_W-1:0] o_out_b,
    output logic [DATA_W-1:0] o_out_c,
    output logic [BW-1:0]     o_bank_idx,
    output logic              o_pair_carry,
    output logic              o_pair_conflict,
    output logic              o_bank_err
);

    localparam int PW = 2 * DATA_W;
    localparam logic [BW-1:0] TOP_BANK = BW'(NBANKS - 1);

    logic [DATA_W-1:0] r_regs [NBANKS][NREGS];
    logic [BW-1:0]     r_bankIdx;
    logic              r_pairCarry;
    logic              r_pairConflict;
    logic              r_bankErr;

    logic [AW-1:0]        w_hi;
    logic [PW-1:0]        w_pair;
    logic signed [PW-1:0] w_immSext;
    logic [PW:0]          w_sum;
    logic                 w_collide;
    logic                 w_pairExec;

    assign w_hi       = i_rd_b_sel + AW'(1);
    assign w_pair     = {r_regs[r_bankIdx][w_hi], r_regs[r_bankIdx][i_rd_b_sel]};
    assign w_immSext  = PW'($signed(i_pair_imm));
    assign w_collide  = i_wr_en && (i_pair_op != 2'b00) &&
                        ((i_wr_sel == i_rd_b_sel) || (i_wr_sel == w_hi));
    assign w_pairExec = (i_pair_op != 2'b00) && !w_collide;

    // Bit PW of the sum is the carry out (or borrow for the decrement).
    always_comb begin
        w_sum = '0;
        case (i_pair_op)
            2'b01:   w_sum = {1'b0, w_pair} + (PW+1)'(1);
            2'b10:   w_sum = {1'b0, w_pair} - (PW+1)'(1);
            2'b11:   w_sum = {1'b0, w_pair} + {1'b0, w_immSext};
            default: w_sum = {1'b0, w_pair};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int r = 0; r < NREGS; r++) begin
                    r_regs[b][r] <= '0;
                end
            end
            r_bankIdx      <= '0;
            r_pairCarry    <= 1'b0;
            r_pairConflict <= 1'b0;
            r_bankErr      <= 1'b0;
        end else begin
            if (w_pairExec) begin
                r_regs[r_bankIdx][i_rd_b_sel] <= w_sum[DATA_W-1:0];
                r_regs[r_bankIdx][w_hi]       <= w_sum[PW-1:DATA_W];
                r_pairCarry                   <= w_sum[PW];
            end
            if (i_wr_en) begin
                r_regs[r_bankIdx][i_wr_sel] <= i_wr_data;
            end
            r_pairConflict <= w_collide;

            // Simultaneous push and pop cancel out without flagging an error.
            if (i_bank_push && !i_bank_pop) begin
                if (r_bankIdx < TOP_BANK) begin
                    r_bankIdx <= r_bankIdx + BW'(1);
                end else begin
                    r_bankErr <= 1'b1;
                end
            end else if (i_bank_pop && !i_bank_push) begin
                if (r_bankIdx != '0) begin
                    r_bankIdx <= r_bankIdx - BW'(1);
                end else begin
                    r_bankErr <= 1'b1;
                end
            end
        end
    end

    assign o_out_a         = r_regs[r_bankIdx][i_wr_sel];
    assign o_out_b         = r_regs[r_bankIdx][i_rd_b_sel];
    assign o_out_c         = r_regs[r_bankIdx][w_hi];
    assign o_bank_idx      = r_bankIdx;
    assign o_pair_carry    = r_pairCarry;
    assign o_pair_conflict = r_pairConflict;
    assign o_bank_err      = r_bankErr;

endmodule

// File: tb/tb_banked_pair_regfile.sv
// Self-checking bench for banked_pair_regfile: arithmetic reference model compared
// every cycle, plus hand-computed literal checks for the directed scenarios.
module tb_banked_pair_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrEn = 1'b0;
    logic [3:0] wrSel = '0;
    logic [7:0] wrData = '0;
    logic [3:0] rdBSel = '0;
    logic [1:0] pairOp = '0;
    logic [7:0] pairImm = '0;
    logic       bankPush = 1'b0;
    logic       bankPop = 1'b0;
    logic [7:0] outA, outB, outC;
    logic       bankIdx;
    logic       pairCarry, pairConflict, bankErr;

    logic [7:0] mdlRegs [2][16];
    int         mdlBank = 0;
    logic       mdlCarry = 1'b0;
    logic       mdlConflict = 1'b0;
    logic       mdlErr = 1'b0;
    bit         modelValid = 1'b0;

    int checks = 0;
    int errors = 0;

    banked_pair_regfile dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wrEn),
        .i_wr_sel       (wrSel),
        .i_wr_data      (wrData),
        .i_rd_b_sel     (rdBSel),
        .i_pair_op      (pairOp),
        .i_pair_imm     (pairImm),
        .i_bank_push    (bankPush),
        .i_bank_pop     (bankPop),
        .o_out_a        (outA),
        .o_out_b        (outB),
        .o_out_c        (outC),
        .o_bank_idx     (bankIdx),
        .o_pair_carry   (pairCarry),
        .o_pair_conflict(pairConflict),
        .o_bank_err     (bankErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: pair value treated as a plain 0..65535 integer.
    task automatic updateModel();
        int unsigned lo, hi, pv, t, res;
        int  s;
        bit  collide, carryNew;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 16; r++) mdlRegs[b][r] = 8'h00;
            mdlBank = 0; mdlCarry = 0; mdlConflict = 0; mdlErr = 0;
            modelValid = 1'b1;
            return;
        end
        if (!modelValid) return;
        lo = rdBSel;
        hi = (lo + 1) % 16;
        collide = wrEn && (pairOp != 0) && (wrSel == lo || wrSel == hi);
        pv = mdlRegs[mdlBank][hi] * 256 + mdlRegs[mdlBank][lo];
        res = pv;
        carryNew = mdlCarry;
        case (pairOp)
            2'd1: begin res = (pv + 1) % 65536; carryNew = (pv == 65535); end
            2'd2: begin res = (pv + 65535) % 65536; carryNew = (pv == 0); end
            2'd3: begin
                s = int'($signed(pairImm));
                t = (s >= 0) ? pv + s : pv + 65536 + s;
                res = t % 65536;
                carryNew = (t >= 65536);
            end
            default: ;
        endcase
        if (pairOp != 0 && !collide) begin
            mdlRegs[mdlBank][lo] = 8'(res % 256);
            mdlRegs[mdlBank][hi] = 8'(res / 256);
            mdlCarry = carryNew;
        end
        if (wrEn) mdlRegs[mdlBank][wrSel] = wrData;
        mdlConflict = collide;
        if (bankPush && !bankPop) begin
            if (mdlBank < 1) mdlBank++; else mdlErr = 1;
        end else if (bankPop && !bankPush) begin
            if (mdlBank > 0) mdlBank--; else mdlErr = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        updateModel();
    end

    // Compare every output against the model once per cycle, away from the clock edge.
    initial forever begin
        @(negedge clk);
        if (modelValid) begin
            checkOutput("mdl_outA", outA, mdlRegs[mdlBank][wrSel]);
            checkOutput("mdl_outB", outB, mdlRegs[mdlBank][rdBSel]);
            checkOutput("mdl_outC", outC, mdlRegs[mdlBank][4'(rdBSel + 4'd1)]);
            checkOutput("mdl_bankIdx", bankIdx, 16'(mdlBank));
            checkOutput("mdl_carry", pairCarry, mdlCarry);
            checkOutput("mdl_conflict", pairConflict, mdlConflict);
            checkOutput("mdl_bankErr", bankErr, mdlErr);
        end
    end

    task automatic applyStimulus(input logic we, input logic [3:0] ws, input logic [7:0] wd,
                                 input logic [3:0] bs, input logic [1:0] op, input logic [7:0] imm,
                                 input logic push, input logic pop);
        @(posedge clk);
        #2;
        wrEn = we; wrSel = ws; wrData = wd; rdBSel = bs;
        pairOp = op; pairImm = imm; bankPush = push; bankPop = pop;
    endtask

    task automatic writeReg(input logic [3:0] sel, input logic [7:0] data);
        applyStimulus(1'b1, sel, data, 4'd0, 2'b00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pairStep(input logic [3:0] bs, input logic [1:0] op, input logic [7:0] imm);
        applyStimulus(1'b0, 4'd0, 8'h00, bs, op, imm, 1'b0, 1'b0);
    endtask

    task automatic idleRead(input logic [3:0] as, input logic [3:0] bs);
        applyStimulus(1'b0, as, 8'h00, bs, 2'b00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic bankStep(input logic push, input logic pop);
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd0, 2'b00, 8'h00, push, pop);
    endtask

    // Reset held for one edge while every other input tries to change state.
    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        wrEn = 1'b1; wrSel = 4'd0; wrData = 8'h5A; rdBSel = 4'd0;
        pairOp = 2'b01; bankPush = 1'b1; bankPop = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        wrEn = 1'b0; pairOp = 2'b00; bankPush = 1'b0; wrData = 8'h00;
    endtask

    task automatic sweepBank();
        for (int i = 0; i < 16; i++) idleRead(4'(i), 4'(i));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Dirty both banks, set carry and error, then reset.
        for (int i = 0; i < 4; i++) writeReg(4'(i), 8'($urandom_range(1, 255)));
        bankStep(1'b1, 1'b0);
        writeReg(4'd10, 8'hFF);
        writeReg(4'd11, 8'hFF);
        pairStep(4'd10, 2'b01, 8'h00);
        bankStep(1'b1, 1'b0);
        idleRead(4'd10, 4'd10);
        @(negedge clk); #1;
        checkOutput("pre_reset_carry", pairCarry, 1'b1);
        checkOutput("pre_reset_err", bankErr, 1'b1);
        doReset();
        @(negedge clk); #1;
        checkOutput("rst_bankIdx", bankIdx, 0);
        checkOutput("rst_carry", pairCarry, 0);
        checkOutput("rst_conflict", pairConflict, 0);
        checkOutput("rst_err", bankErr, 0);
        checkOutput("rst_outA", outA, 0);
        sweepBank();
        bankStep(1'b1, 1'b0);
        sweepBank();
        bankStep(1'b0, 1'b1);

        // Pair increment wrap and no-wrap.
        writeReg(4'd3, 8'hFF);
        writeReg(4'd2, 8'hFF);
        pairStep(4'd2, 2'b01, 8'h00);
        idleRead(4'd3, 4'd2);
        @(negedge clk); #1;
        checkOutput("inc_wrap_R2", outB, 8'h00);
        checkOutput("inc_wrap_R3", outC, 8'h00);
        checkOutput("inc_wrap_carry", pairCarry, 1'b1);
        writeReg(4'd2, 8'hFF);
        writeReg(4'd3, 8'h00);
        pairStep(4'd2, 2'b01, 8'h00);
        idleRead(4'd3, 4'd2);
        @(negedge clk); #1;
        checkOutput("inc_R2", outB, 8'h00);
        checkOutput("inc_R3", outC, 8'h01);
        checkOutput("inc_carry", pairCarry, 1'b0);

        // Signed immediate add, then decrement borrow, then positive immediates.
        writeReg(4'd4, 8'h10);
        writeReg(4'd5, 8'h00);
        pairStep(4'd4, 2'b11, 8'hF0);
        idleRead(4'd5, 4'd4);
        @(negedge clk); #1;
        checkOutput("imm_neg_pair", {outC, outB}, 16'h0000);
        checkOutput("imm_neg_carry", pairCarry, 1'b1);
        pairStep(4'd4, 2'b10, 8'h00);
        idleRead(4'd5, 4'd4);
        @(negedge clk); #1;
        checkOutput("dec_pair", {outC, outB}, 16'hFFFF);
        checkOutput("dec_borrow", pairCarry, 1'b1);
        writeReg(4'd8, 8'hF0);
        writeReg(4'd9, 8'h00);
        pairStep(4'd8, 2'b11, 8'h20);
        idleRead(4'd9, 4'd8);
        @(negedge clk); #1;
        checkOutput("imm_pos_pair", {outC, outB}, 16'h0110);
        checkOutput("imm_pos_carry", pairCarry, 1'b0);
        writeReg(4'd8, 8'hF0);
        writeReg(4'd9, 8'hFF);
        pairStep(4'd8, 2'b11, 8'h7F);
        idleRead(4'd9, 4'd8);
        @(negedge clk); #1;
        checkOutput("imm_pos_wrap_pair", {outC, outB}, 16'h006F);
        checkOutput("imm_pos_wrap_carry", pairCarry, 1'b1);

        // Write collision suppresses pair op; non-colliding write runs alongside.
        writeReg(4'd6, 8'h55);
        writeReg(4'd7, 8'h33);
        applyStimulus(1'b1, 4'd7, 8'hAA, 4'd6, 2'b01, 8'h00, 1'b0, 1'b0);
        idleRead(4'd7, 4'd6);
        @(negedge clk); #1;
        checkOutput("coll_R7", outA, 8'hAA);
        checkOutput("coll_R6", outB, 8'h55);
        checkOutput("coll_pulse", pairConflict, 1'b1);
        checkOutput("coll_carry_hold", pairCarry, 1'b1);
        idleRead(4'd7, 4'd6);
        @(negedge clk); #1;
        checkOutput("coll_pulse_end", pairConflict, 1'b0);
        applyStimulus(1'b1, 4'd9, 8'h5C, 4'd6, 2'b01, 8'h00, 1'b0, 1'b0);
        idleRead(4'd9, 4'd6);
        @(negedge clk); #1;
        checkOutput("nocoll_R9", outA, 8'h5C);
        checkOutput("nocoll_R6", outB, 8'h56);
        checkOutput("nocoll_R7", outC, 8'hAA);
        checkOutput("nocoll_flag", pairConflict, 1'b0);

        // R15 pairs with R0.
        writeReg(4'd15, 8'hFF);
        writeReg(4'd0, 8'h00);
        pairStep(4'd15, 2'b01, 8'h00);
        idleRead(4'd15, 4'd15);
        @(negedge clk); #1;
        checkOutput("edge_R15", outB, 8'h00);
        checkOutput("edge_R0", outC, 8'h01);

        // Bank stack behaviour.
        writeReg(4'd1, 8'h11);
        bankStep(1'b1, 1'b0);
        writeReg(4'd1, 8'h22);
        idleRead(4'd1, 4'd1);
        @(negedge clk); #1;
        checkOutput("bank1_R1", outA, 8'h22);
        checkOutput("bank1_idx", bankIdx, 1);
        bankStep(1'b0, 1'b1);
        idleRead(4'd1, 4'd1);
        @(negedge clk); #1;
        checkOutput("bank0_R1", outA, 8'h11);
        bankStep(1'b1, 1'b0);
        bankStep(1'b1, 1'b0);
        idleRead(4'd1, 4'd1);
        @(negedge clk); #1;
        checkOutput("push_top_idx", bankIdx, 1);
        checkOutput("push_top_err", bankErr, 1'b1);
        doReset();
        bankStep(1'b0, 1'b1);
        idleRead(4'd0, 4'd0);
        @(negedge clk); #1;
        checkOutput("pop_zero_idx", bankIdx, 0);
        checkOutput("pop_zero_err", bankErr, 1'b1);
        doReset();
        bankStep(1'b1, 1'b1);
        applyStimulus(1'b1, 4'd2, 8'h77, 4'd0, 2'b00, 8'h00, 1'b1, 1'b0);
        bankStep(1'b1, 1'b1);
        idleRead(4'd2, 4'd2);
        @(negedge clk); #1;
        checkOutput("pushpop_idx", bankIdx, 1);
        checkOutput("pushpop_err", bankErr, 1'b0);
        checkOutput("push_write_old_bank", outA, 8'h00);
        bankStep(1'b0, 1'b1);
        idleRead(4'd2, 4'd2);
        @(negedge clk); #1;
        checkOutput("bank0_R2", outA, 8'h77);

        idleRead(4'd0, 4'd0);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
